// File: rtl/reg_bank_pkg.sv
// Operation codes shared by the register bank, its op unit and the controller that drives op.
package reg_bank_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_NOP   = 3'b000;
   localparam logic [OP_W-1:0] OP_LOAD  = 3'b001;
   localparam logic [OP_W-1:0] OP_CLEAR = 3'b010;
   localparam logic [OP_W-1:0] OP_INC   = 3'b011;
   localparam logic [OP_W-1:0] OP_DEC   = 3'b100;
   localparam logic [OP_W-1:0] OP_SHL   = 3'b101;
   localparam logic [OP_W-1:0] OP_SHR   = 3'b110;
   localparam logic [OP_W-1:0] OP_ROTL  = 3'b111;

   function automatic logic is_write_op(input logic [OP_W-1:0] op);
      return op != OP_NOP;
   endfunction

endpackage

// File: rtl/reg_op_unit.sv
// Combinational next-value and carry for one register under one operation; zero latency,
// no flow control.
module reg_op_unit
   import reg_bank_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] old_val,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] din,
   input  logic             shift_in,
   output logic [WIDTH-1:0] new_val,
   output logic             carry
);

   logic [WIDTH:0] inc_sum;
   logic [WIDTH:0] dec_diff;

   // One extra bit catches the wrap: carry on all-ones increment, borrow on zero decrement.
   assign inc_sum  = {1'b0, old_val} + (WIDTH+1)'(1);
   assign dec_diff = {1'b0, old_val} - (WIDTH+1)'(1);

   always_comb begin
      new_val = old_val;
      carry   = 1'b0;
      case (op)
         OP_LOAD: begin
            new_val = din;
         end
         OP_CLEAR: begin
            new_val = '0;
         end
         OP_INC: begin
            new_val = inc_sum[WIDTH-1:0];
            carry   = inc_sum[WIDTH];
         end
         OP_DEC: begin
            new_val = dec_diff[WIDTH-1:0];
            carry   = dec_diff[WIDTH];
         end
         OP_SHL: begin
            new_val = {old_val[WIDTH-2:0], shift_in};
            carry   = old_val[WIDTH-1];
         end
         OP_SHR: begin
            new_val = {shift_in, old_val[WIDTH-1:1]};
            carry   = old_val[0];
         end
         OP_ROTL: begin
            new_val = {old_val[WIDTH-2:0], old_val[WIDTH-1]};
            carry   = old_val[WIDTH-1];
         end
         default: begin
            new_val = old_val;
            carry   = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/reg_bank_multimode.sv
// Bank of DEPTH registers with one op-coded write port, two combinational read ports and
// registered carry/zero flags; write latency 1, read latency 0, never stalls.
module reg_bank_multimode
   import reg_bank_pkg::*;
#(
   parameter  int WIDTH  = 16,
   parameter  int DEPTH  = 8,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [OP_W-1:0]   op,
   input  logic [WIDTH-1:0]  din,
   input  logic              shift_in,
   input  logic [ADDR_W-1:0] rd_addr_a,
   output logic [WIDTH-1:0]  rd_data_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [WIDTH-1:0]  rd_data_b,
   output logic              carry_out,
   output logic              zero_flag
);

   logic [WIDTH-1:0] regs [DEPTH];

   logic [WIDTH-1:0] wr_old;
   logic [WIDTH-1:0] wr_new;
   logic             wr_carry;
   logic             wr_hit;
   logic             wr_eff;

   // Decoding by comparison keeps out-of-range addresses (DEPTH not a power of two) harmless.
   always_comb begin
      wr_old = '0;
      wr_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_addr == ADDR_W'(i)) begin
            wr_old = regs[i];
            wr_hit = 1'b1;
         end
      end
   end

   assign wr_eff = wr_en & wr_hit & is_write_op(op);

   reg_op_unit #(
      .WIDTH (WIDTH)
   ) u_op_unit (
      .old_val  (wr_old),
      .op       (op),
      .din      (din),
      .shift_in (shift_in),
      .new_val  (wr_new),
      .carry    (wr_carry)
   );

   always_comb begin
      rd_data_a = '0;
      rd_data_b = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (rd_addr_a == ADDR_W'(i)) begin
            rd_data_a = regs[i];
         end
         if (rd_addr_b == ADDR_W'(i)) begin
            rd_data_b = regs[i];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
         carry_out <= 1'b0;
         zero_flag <= 1'b0;
      end else if (wr_eff) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_addr == ADDR_W'(i)) begin
               regs[i] <= wr_new;
            end
         end
         carry_out <= wr_carry;
         zero_flag <= (wr_new == '0);
      end
   end

endmodule

// File: tb/tb_reg_bank_multimode.sv
// Two bank instances (16x6 and 8x4) driven by directed then random ops against an arithmetic model.
module tb_reg_bank_multimode;
   import reg_bank_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst [2];
   logic        en  [2];
   logic [2:0]  wa  [2];
   logic [2:0]  opk [2];
   logic [2:0]  ra  [2];
   logic [2:0]  rb  [2];
   logic [15:0] dn  [2];
   logic        si  [2];

   logic [15:0] a_rda, a_rdb;
   logic        a_c, a_z;
   logic [7:0]  b_rda, b_rdb;
   logic        b_c, b_z;

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   reg_bank_multimode #(.WIDTH(16), .DEPTH(6)) u_a (
      .clock(clk), .reset(rst[0]), .wr_en(en[0]), .wr_addr(wa[0]), .op(opk[0]),
      .din(dn[0]), .shift_in(si[0]), .rd_addr_a(ra[0]), .rd_data_a(a_rda),
      .rd_addr_b(rb[0]), .rd_data_b(a_rdb), .carry_out(a_c), .zero_flag(a_z)
   );

   reg_bank_multimode #(.WIDTH(8), .DEPTH(4)) u_b (
      .clock(clk), .reset(rst[1]), .wr_en(en[1]), .wr_addr(wa[1][1:0]), .op(opk[1]),
      .din(dn[1][7:0]), .shift_in(si[1]), .rd_addr_a(ra[1][1:0]), .rd_data_a(b_rda),
      .rd_addr_b(rb[1][1:0]), .rd_data_b(b_rdb), .carry_out(b_c), .zero_flag(b_z)
   );

   // Reference model: register contents as plain integers, masked to each instance's width.
   int unsigned mreg [2][8];
   logic        mc [2];
   logic        mz [2];
   int unsigned mw [2] = '{16, 8};
   int unsigned md [2] = '{6, 4};

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic logic [31:0] mread(int k, logic [2:0] a);
      return (32'(a) < md[k]) ? mreg[k][a] : 32'd0;
   endfunction

   function automatic void model_step(int k);
      int unsigned w, mask, old, nv;
      logic c;
      w    = mw[k];
      mask = (32'd1 << w) - 1;
      if (rst[k]) begin
         for (int i = 0; i < 8; i++) mreg[k][i] = 0;
         mc[k] = 1'b0;
         mz[k] = 1'b0;
         return;
      end
      if (!en[k] || opk[k] == OP_NOP || 32'(wa[k]) >= md[k]) return;
      old = mreg[k][wa[k]];
      c   = 1'b0;
      case (opk[k])
         OP_LOAD:  nv = 32'(dn[k]) & mask;
         OP_CLEAR: nv = 0;
         OP_INC:   begin nv = (old + 1) & mask; c = (old == mask); end
         OP_DEC:   begin nv = (old - 1) & mask; c = (old == 0); end
         OP_SHL:   begin nv = ((old << 1) | 32'(si[k])) & mask; c = ((old >> (w - 1)) != 0); end
         OP_SHR:   begin nv = (32'(si[k]) << (w - 1)) | (old >> 1); c = ((old & 1) != 0); end
         default:  begin nv = ((old << 1) | (old >> (w - 1))) & mask; c = ((old >> (w - 1)) != 0); end
      endcase
      mreg[k][wa[k]] = nv;
      mc[k] = c;
      mz[k] = (nv == 0);
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) model_step(k);
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("a_rd_a",  32'(a_rda), mread(0, ra[0]));
         chk("a_rd_b",  32'(a_rdb), mread(0, rb[0]));
         chk("a_carry", 32'(a_c),   32'(mc[0]));
         chk("a_zero",  32'(a_z),   32'(mz[0]));
         chk("b_rd_a",  32'(b_rda), mread(1, ra[1]));
         chk("b_rd_b",  32'(b_rdb), mread(1, rb[1]));
         chk("b_carry", 32'(b_c),   32'(mc[1]));
         chk("b_zero",  32'(b_z),   32'(mz[1]));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(int k, logic [2:0] a, logic [2:0] o, logic [15:0] d, logic s);
      en[k] = 1'b1; wa[k] = a; opk[k] = o; dn[k] = d; si[k] = s;
   endtask

   task automatic wr(int k, logic [2:0] a, logic [2:0] o, logic [15:0] d, logic s);
      drive(k, a, o, d, s);
      step();
      en[k] = 1'b0;
   endtask

   task automatic peek(int k, string nm, logic [2:0] a, logic [15:0] exp);
      ra[k] = a;
      #1;
      chk(nm, (k == 0) ? 32'(a_rda) : 32'(b_rda), 32'(exp));
   endtask

   task automatic flags(int k, string nm, logic c, logic z);
      chk({nm, "_c"}, (k == 0) ? 32'(a_c) : 32'(b_c), 32'(c));
      chk({nm, "_z"}, (k == 0) ? 32'(a_z) : 32'(b_z), 32'(z));
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         en[k] = 1'b0; wa[k] = '0; opk[k] = OP_NOP; dn[k] = '0; si[k] = 1'b0;
         ra[k] = '0; rb[k] = '0; rst[k] = 1'b1;
      end
      // Reset must beat a simultaneous load.
      drive(0, 3'd0, OP_LOAD, 16'h1234, 1'b0);
      drive(1, 3'd0, OP_LOAD, 16'h0012, 1'b0);
      step();
      rst[0] = 1'b0; rst[1] = 1'b0; en[0] = 1'b0; en[1] = 1'b0;
      chk_on = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ra[0] = 3'(i); rb[0] = 3'(i + 3); ra[1] = 3'(i); rb[1] = 3'(i + 1);
         #1;
         chk("rst_a_rd_a", 32'(a_rda), 32'd0);
         chk("rst_a_rd_b", 32'(a_rdb), 32'd0);
         chk("rst_b_rd_a", 32'(b_rda), 32'd0);
      end
      flags(0, "rst_a", 1'b0, 1'b0);
      flags(1, "rst_b", 1'b0, 1'b0);

      wr(0, 3'd3, OP_LOAD, 16'hFFFF, 1'b0);
      wr(0, 3'd3, OP_INC, 16'h0, 1'b0);
      peek(0, "inc_wrap", 3'd3, 16'h0000);
      flags(0, "inc_wrap", 1'b1, 1'b1);
      wr(0, 3'd3, OP_DEC, 16'h0, 1'b0);
      peek(0, "dec_wrap", 3'd3, 16'hFFFF);
      flags(0, "dec_wrap", 1'b1, 1'b0);

      wr(0, 3'd5, OP_LOAD, 16'h8001, 1'b0);
      wr(0, 3'd5, OP_SHL, 16'h0, 1'b0);
      peek(0, "shl", 3'd5, 16'h0002);
      flags(0, "shl", 1'b1, 1'b0);
      wr(0, 3'd5, OP_SHR, 16'h0, 1'b1);
      peek(0, "shr", 3'd5, 16'h8001);
      flags(0, "shr", 1'b0, 1'b0);
      wr(0, 3'd5, OP_ROTL, 16'h0, 1'b0);
      peek(0, "rotl", 3'd5, 16'h0003);
      flags(0, "rotl", 1'b1, 1'b0);

      // Same-cycle read of the register being written sees the old value.
      ra[0] = 3'd2; rb[0] = 3'd2;
      drive(0, 3'd2, OP_LOAD, 16'hABCD, 1'b0);
      #1;
      chk("hazard_pre_a", 32'(a_rda), 32'h0);
      chk("hazard_pre_b", 32'(a_rdb), 32'h0);
      step();
      en[0] = 1'b0;
      #1;
      chk("hazard_post_a", 32'(a_rda), 32'hABCD);
      chk("hazard_post_b", 32'(a_rdb), 32'hABCD);

      wr(0, 3'd1, OP_INC, 16'h0, 1'b0);
      peek(0, "inc_r1", 3'd1, 16'h0001);
      flags(0, "inc_r1", 1'b0, 1'b0);
      wr(0, 3'd3, OP_INC, 16'h0, 1'b0);
      flags(0, "inc_r3", 1'b1, 1'b1);
      wr(0, 3'd1, OP_NOP, 16'h0, 1'b0);
      drive(0, 3'd1, OP_INC, 16'h0, 1'b0);
      en[0] = 1'b0;
      step();
      wr(0, 3'd7, OP_LOAD, 16'h5555, 1'b1);
      wr(0, 3'd6, OP_DEC, 16'h0, 1'b0);
      peek(0, "supp_r1", 3'd1, 16'h0001);
      peek(0, "supp_r3", 3'd3, 16'h0000);
      peek(0, "oob_read", 3'd7, 16'h0000);
      flags(0, "supp", 1'b1, 1'b1);

      // Reset between increments: counting restarts from zero.
      drive(0, 3'd0, OP_INC, 16'h0, 1'b0);
      drive(1, 3'd0, OP_INC, 16'h0, 1'b0);
      step(); step(); step();
      rst[0] = 1'b1; rst[1] = 1'b1;
      step();
      rst[0] = 1'b0; rst[1] = 1'b0;
      step();
      en[0] = 1'b0; en[1] = 1'b0;
      peek(0, "a_rst_inc", 3'd0, 16'h0001);
      peek(1, "b_rst_inc", 3'd0, 16'h0001);
      flags(0, "a_rst_inc", 1'b0, 1'b0);
      flags(1, "b_rst_inc", 1'b0, 1'b0);

      wr(1, 3'd1, OP_LOAD, 16'h00FF, 1'b0);
      wr(1, 3'd1, OP_INC, 16'h0, 1'b0);
      peek(1, "b_inc_wrap", 3'd1, 16'h0000);
      flags(1, "b_inc_wrap", 1'b1, 1'b1);
      wr(1, 3'd2, OP_SHR, 16'h0, 1'b1);
      peek(1, "b_shr", 3'd2, 16'h0080);
      flags(1, "b_shr", 1'b0, 1'b0);

      for (int n = 0; n < 3000; n++) begin
         for (int k = 0; k < 2; k++) begin
            logic [15:0] mask;
            mask   = (k == 0) ? 16'hFFFF : 16'h00FF;
            rst[k] = ($urandom_range(0, 63) == 0);
            en[k]  = ($urandom_range(0, 3) != 0);
            wa[k]  = 3'($urandom_range(0, (k == 0) ? 7 : 3));
            opk[k] = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
               0:       dn[k] = 16'h0;
               1:       dn[k] = mask;
               default: dn[k] = 16'($urandom) & mask;
            endcase
            si[k]  = 1'($urandom);
            ra[k]  = 3'($urandom_range(0, (k == 0) ? 7 : 3));
            rb[k]  = 3'($urandom_range(0, (k == 0) ? 7 : 3));
         end
         step();
      end

      rst[0] = 1'b0; rst[1] = 1'b0; en[0] = 1'b0; en[1] = 1'b0;
      step();
      chk_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
